// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI output path.
//   - TMDS control-period codes and a lookup helper.
//   - Timing constant sets for 640x480@60 and 1280x720@60.
//   - Frame sequencer state enum.
package hdmi_pkg;

  // Raster counter width; every H/V total must stay <= 4095.
  localparam int CNT_W = 12;

  // TMDS control-period characters, indexed by {c1, c0}.
  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

  function automatic logic [9:0] tmds_ctrl_code(input logic [1:0] c);
    logic [9:0] code;
    case (c)
      2'b00:   code = TMDS_CTRL_00;
      2'b01:   code = TMDS_CTRL_01;
      2'b10:   code = TMDS_CTRL_10;
      default: code = TMDS_CTRL_11;
    endcase
    return code;
  endfunction

  // 640x480@60 (25.175 MHz pixel clock), negative syncs.
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam bit VGA_HS_POL   = 1'b0;
  localparam bit VGA_VS_POL   = 1'b0;

  // 1280x720@60 (74.25 MHz pixel clock), positive syncs.
  localparam int HD720_H_ACTIVE = 1280;
  localparam int HD720_H_FP     = 110;
  localparam int HD720_H_SYNC   = 40;
  localparam int HD720_H_BP     = 220;
  localparam int HD720_V_ACTIVE = 720;
  localparam int HD720_V_FP     = 5;
  localparam int HD720_V_SYNC   = 5;
  localparam int HD720_V_BP     = 20;
  localparam bit HD720_HS_POL   = 1'b1;
  localparam bit HD720_VS_POL   = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

endpackage

// File: rtl/hdmi_frame_sequencer_if.sv
// Bundle between the frame sequencer, the camera frame buffer and the
// three TMDS encoders.
//   master : the sequencer (consumes pixels, drives encoder inputs/debug)
//   slave  : the environment (frame buffer + encoders)
//
// Pixel handshake: a pixel transfers in every cycle where
// pix_ready && pix_valid. pix_ready depends only on the sequencer's raster
// position and never on pix_valid; the frame buffer must not wait for
// pix_ready before raising pix_valid. A cycle with pix_ready high and
// pix_valid low is an underflow: that pixel is shown black and skipped,
// the frame buffer's next pixel goes to the next raster position.
// frame_start marks the request of pixel (0,0); the frame buffer rewinds
// its read pointer on frame_start && pix_ready.
interface hdmi_frame_sequencer_if;
  import hdmi_pkg::*;

  logic        enable;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_ready;
  logic        frame_start;
  logic        enc_sel;
  logic [7:0]  enc_data_r;
  logic [7:0]  enc_data_g;
  logic [7:0]  enc_data_b;
  logic [1:0]  enc_ctrl_b;
  logic [1:0]  enc_ctrl_g;
  logic [1:0]  enc_ctrl_r;
  logic        busy;
  logic        underflow;
  logic [15:0] underflow_cnt;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  seq_state_t  state;

  modport master (
    input  enable, pix_valid, pix_data,
    output pix_ready, frame_start, enc_sel, enc_data_r, enc_data_g,
           enc_data_b, enc_ctrl_b, enc_ctrl_g, enc_ctrl_r, busy,
           underflow, underflow_cnt, h_cnt, v_cnt, state
  );

  modport slave (
    output enable, pix_valid, pix_data,
    input  pix_ready, frame_start, enc_sel, enc_data_r, enc_data_g,
           enc_data_b, enc_ctrl_b, enc_ctrl_g, enc_ctrl_r, busy,
           underflow, underflow_cnt, h_cnt, v_cnt, state
  );
endinterface

// File: rtl/video_timing_counter.sv
// Raster position counters and region decode.
// Ports:
//   clk, rst   pixel clock, synchronous active-high reset
//   clr        hold both counters at 0
//   adv        advance one pixel this cycle
//   h_cnt      0..H_TOTAL-1, wraps
//   v_cnt      0..V_TOTAL-1, steps on each h wrap
//   active     inside the visible area
//   hs_act     inside the hsync pulse (level-independent)
//   vs_act     inside the vsync pulse (level-independent)
//   eof        last pixel of the frame (h=H_TOTAL-1, v=V_TOTAL-1)
module video_timing_counter import hdmi_pkg::*; #(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             active,
  output logic             hs_act,
  output logic             vs_act,
  output logic             eof
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_N = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_N = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic h_wrap;

  assign h_wrap = (h_cnt == H_LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (adv) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end
  end

  assign active = (h_cnt < H_ACT_N) && (v_cnt < V_ACT_N);
  assign hs_act = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs_act = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  assign eof    = h_wrap && (v_cnt == V_LAST);

endmodule

// File: rtl/hdmi_frame_sequencer.sv
// Frame sequencer for the three TMDS encoders of the HDMI output.
// Generates raster timing, pulls RGB pixels from the frame buffer and
// presents one registered, aligned word per pixel clock to the encoders.
// Ports:
//   clk   pixel clock
//   rst   synchronous reset, active high (dominates enable)
//   bus   master side of hdmi_frame_sequencer_if:
//         enable/pix_valid/pix_data in; pix_ready, frame_start, enc_*,
//         busy, underflow, underflow_cnt, h_cnt, v_cnt, state out
module hdmi_frame_sequencer import hdmi_pkg::*; #(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit HS_POL   = VGA_HS_POL,
  parameter bit VS_POL   = VGA_VS_POL
) (
  input logic                   clk,
  input logic                   rst,
  hdmi_frame_sequencer_if.master bus
);

  // Sync levels outside the pulse; also the idle/reset ctrl word.
  localparam logic [1:0] CTRL_IDLE = {~VS_POL, ~HS_POL};

  seq_state_t       state_q;
  seq_state_t       state_d;
  logic             running;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             active;
  logic             hs_act;
  logic             vs_act;
  logic             eof;
  logic             hsync;
  logic             vsync;
  logic             pix_ready;
  logic             starved;

  logic             enc_sel_q;
  logic [23:0]      enc_data_q;
  logic [1:0]       enc_ctrl_b_q;
  logic             underflow_q;
  logic [15:0]      underflow_cnt_q;

  assign running = (state_q == RUN) || (state_q == DRAIN);

  video_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == IDLE),
    .adv    (running),
    .h_cnt  (h_cnt),
    .v_cnt  (v_cnt),
    .active (active),
    .hs_act (hs_act),
    .vs_act (vs_act),
    .eof    (eof)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. DRAIN keeps the raster going so a frame is never cut
  // short; re-enabling during DRAIN resumes RUN without a gap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.enable) state_d = RUN;
      end
      RUN: begin
        if (!bus.enable) state_d = DRAIN;
      end
      DRAIN: begin
        if (bus.enable)  state_d = RUN;
        else if (eof)    state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign hsync     = hs_act ? HS_POL : ~HS_POL;
  assign vsync     = vs_act ? VS_POL : ~VS_POL;
  assign pix_ready = running && active;
  assign starved   = pix_ready && !bus.pix_valid;

  // One register stage towards the encoders. A starved active pixel is
  // shown as black with enc_sel kept high so the raster timing holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      enc_sel_q       <= 1'b0;
      enc_data_q      <= '0;
      enc_ctrl_b_q    <= CTRL_IDLE;
      underflow_q     <= 1'b0;
      underflow_cnt_q <= '0;
    end else begin
      enc_sel_q    <= pix_ready;
      enc_data_q   <= (pix_ready && bus.pix_valid) ? bus.pix_data : 24'h000000;
      enc_ctrl_b_q <= running ? {vsync, hsync} : CTRL_IDLE;
      underflow_q  <= starved;
      if (starved && (underflow_cnt_q != 16'hFFFF)) begin
        underflow_cnt_q <= underflow_cnt_q + 16'd1;
      end
    end
  end

  assign bus.pix_ready     = pix_ready;
  assign bus.frame_start   = pix_ready && (h_cnt == '0) && (v_cnt == '0);
  assign bus.enc_sel       = enc_sel_q;
  assign bus.enc_data_r    = enc_data_q[23:16];
  assign bus.enc_data_g    = enc_data_q[15:8];
  assign bus.enc_data_b    = enc_data_q[7:0];
  assign bus.enc_ctrl_b    = enc_ctrl_b_q;
  assign bus.enc_ctrl_g    = 2'b00;
  assign bus.enc_ctrl_r    = 2'b00;
  assign bus.busy          = (state_q != IDLE);
  assign bus.underflow     = underflow_q;
  assign bus.underflow_cnt = underflow_cnt_q;
  assign bus.h_cnt         = h_cnt;
  assign bus.v_cnt         = v_cnt;
  assign bus.state         = state_q;

endmodule
